nic2noc_vc_queue: RTL and testbench
===================================

NIC2NOC_VC_QUEUE -- requirements
Module: nic2noc_vc_queue

Interface
REQ-001 The block SHALL have parameter N_TOT_OF_VC, default `N_OF_VC*`N_OF_VN, meaning the total virtual channels (VN x VC).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4 (power of 2, >=2), meaning the flit slots per VC.
REQ-003 The block SHALL have parameter FLIT_WIDTH, default `FLIT_WIDTH, meaning the flit width in bits.
REQ-004 The block SHALL have parameter MAX_CREDIT, default 4, meaning the downstream buffer slots per VC.
REQ-005 The block SHALL have parameter N_BITS_POINTER, default clog2(FIFO_DEPTH), meaning the FIFO pointer width.
REQ-006 Port clk SHALL be an input of width 1 and SHALL be the single clock, with all state on its rising edge.
REQ-007 Port rst SHALL be an input of width 1 and SHALL be the asynchronous, active-low reset.
REQ-008 Port in_link_i SHALL be an input of width FLIT_WIDTH carrying the flit from wb_slave_interface.
REQ-009 Port in_vc_i SHALL be an input of width N_TOT_OF_VC giving the one-hot target VC of in_link_i.
REQ-010 Port is_valid_i SHALL be an input of width 1 qualifying in_link_i/in_vc_i.
REQ-011 Port fifo_full_o SHALL be an output of width N_TOT_OF_VC giving per-VC FIFO full.
REQ-012 Port credit_signal_i SHALL be an input of width N_TOT_OF_VC carrying per-VC credit return pulses from the NoC.
REQ-013 Port out_link_o SHALL be an output of width FLIT_WIDTH carrying the flit to the NoC.
REQ-014 Port out_vc_o SHALL be an output of width N_TOT_OF_VC giving the one-hot VC of out_link_o.
REQ-015 Port is_valid_o SHALL be an output of width 1 qualifying out_link_o/out_vc_o.
REQ-016 Port free_signal_o SHALL be an output of width N_TOT_OF_VC pulsing when a tail flit leaves that VC.
REQ-017 Port fifo_empty_o SHALL be an output of width N_TOT_OF_VC giving per-VC FIFO empty.

Function
REQ-018 A write SHALL occur when is_valid_i=1, in_vc_i is one-hot and that VC's registered fifo_full_o=0; otherwise the flit SHALL be dropped, with no bypass of a full FIFO even on a same-cycle pop.
REQ-019 A non-one-hot in_vc_i SHALL cause no write.
REQ-020 Per-VC read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy width N_BITS_POINTER+1; full at FIFO_DEPTH, empty at 0.
REQ-021 Per-VC credit counter: reset MAX_CREDIT; -1 on send; +1 on credit_signal_i; send and credit in same cycle leave it unchanged; increment at MAX_CREDIT ignored (saturate).
REQ-022 A VC SHALL be eligible when it is non-empty and its credit > 0.
REQ-023 Round-robin arbitration SHALL pick at most one eligible VC per cycle; the priority pointer SHALL move to winner+1 (mod N_TOT_OF_VC) and hold when there is no grant.
REQ-024 The winner's head flit SHALL be popped and registered onto out_link_o/out_vc_o with is_valid_o=1 at the next edge; when there is no grant, all three SHALL be 0.
REQ-025 Latency: a flit accepted in cycle n SHALL appear on out_link_o no earlier than cycle n+2, with no empty-FIFO bypass.
REQ-026 Throughput SHALL be 1 flit/cycle aggregate, with back-to-back sends from one VC allowed while credit > 0.
REQ-027 Flit type is bits [FLIT_WIDTH-1:FLIT_WIDTH-2]; when a sent flit is TAIL or HEAD_TAIL, free_signal_o[vc] SHALL be 1 in the same cycle as is_valid_o.

Reset
REQ-028 While rst=0, all FIFOs SHALL empty (fifo_empty_o all 1, fifo_full_o 0), credits SHALL be MAX_CREDIT, the RR pointer SHALL be 0, and out_link_o, out_vc_o, is_valid_o and free_signal_o SHALL be 0, including mid-packet; flits held at reset SHALL be lost.

Configuration
REQ-029 With `NIC_OUT_STATS_EN defined, the block SHALL add output flits_sent_o[31:0]: reset 0, +1 per is_valid_o cycle, wrapping at 2^32; without the macro the port and counter SHALL be absent.

Structure
REQ-030 clog2, the flit-type field position and encodings (HEAD, BODY, TAIL, HEAD_TAIL) SHALL live in shared package nic_pkg.
REQ-031 The round-robin arbiter SHALL be sub-module nic_rr_arbiter (parameter N, request/grant one-hot, advance input); the FIFOs SHALL stay in-line.

Verification (N_TOT_OF_VC=6, FIFO_DEPTH=4, MAX_CREDIT=2)
REQ-032 One BODY flit 0x15 to VC2, no other traffic -> is_valid_o=1, out_vc_o=6'b000100, out_link_o=0x15 two cycles after is_valid_i.
REQ-033 Five writes to VC0 with no credits returned -> 5th dropped, fifo_full_o[0]=1 after the 4th; 2 flits sent, then is_valid_o stays 0; one credit_signal_i[0] pulse -> exactly one more flit.
REQ-034 VC1, VC3 and VC5 each hold 2 flits with full credit -> output order VC1,VC3,VC5,VC1,VC3,VC5, with no idle cycles.
REQ-035 credit_signal_i[4] pulsed with VC4 at 2 credits -> counter stays 2; send and credit in the same cycle -> counter unchanged.
REQ-036 HEAD, BODY, TAIL to VC0 -> free_signal_o[0]=1 only in the TAIL output cycle.
REQ-037 rst driven low while 3 VCs are non-empty -> all outputs 0 and fifo_empty_o=6'b111111 immediately, with no flit emitted after release until new writes arrive.

Source files
------------

// File: rtl/nic_pkg.sv
// nic_pkg: shared NIC helpers, flit-type field layout and encodings.
package nic_pkg;
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction
    // Flit type lives in the top FLIT_TYPE_W bits of every flit.
    localparam int FLIT_TYPE_W = 2;
    typedef enum logic [FLIT_TYPE_W-1:0] {
        HEAD      = 2'b00,
        BODY      = 2'b01,
        TAIL      = 2'b10,
        HEAD_TAIL = 2'b11
    } flit_type_e;
endpackage

// File: rtl/nic_rr_arbiter.sv
// nic_rr_arbiter: round-robin one-hot arbiter; priority moves to winner+1 on an advanced grant.
module nic_rr_arbiter
    import nic_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] request,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PW = N > 1 ? clog2(N) : 1;
    localparam int LAST_I = N - 1;
    localparam logic [PW:0] NL = N[PW:0];
    localparam logic [PW-1:0] LAST = LAST_I[PW-1:0];
    logic [PW-1:0] ptr, win;
    logic [N-1:0] rot;
    logic [PW:0] sum, wrap;
    // Rotate requests so the pointer sits at bit 0, then take the lowest set bit.
    always_comb begin
        rot = N'({request, request} >> ptr);
        sum = '0;
        grant = '0;
        for (int i = N - 1; i >= 0; i--) if (rot[i]) sum = (PW+1)'(i);
        sum = sum + {1'b0, ptr};
        wrap = sum - NL;
        win = sum >= NL ? wrap[PW-1:0] : sum[PW-1:0];
        for (int k = 0; k < N; k++) grant[k] = |rot && win == PW'(k);
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) ptr <= '0;
        else if (advance && |grant) ptr <= win == LAST ? '0 : win + 1'b1;
endmodule

// File: rtl/nic2noc_vc_queue.sv
// nic2noc_vc_queue: per-VC flit FIFOs with credit flow control and round-robin send to the NoC.
// Optional NIC_OUT_STATS_EN adds a 32-bit sent-flit counter output flits_sent_o.
`ifndef N_OF_VC
`define N_OF_VC 2
`endif
`ifndef N_OF_VN
`define N_OF_VN 3
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
module nic2noc_vc_queue
    import nic_pkg::*;
#(
    parameter int N_TOT_OF_VC    = `N_OF_VC * `N_OF_VN,
    parameter int FIFO_DEPTH     = 4,
    parameter int FLIT_WIDTH     = `FLIT_WIDTH,
    parameter int MAX_CREDIT     = 4,
    parameter int N_BITS_POINTER = clog2(FIFO_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_WIDTH-1:0]  in_link_i,
    input  logic [N_TOT_OF_VC-1:0] in_vc_i,
    input  logic                   is_valid_i,
    output logic [N_TOT_OF_VC-1:0] fifo_full_o,
    input  logic [N_TOT_OF_VC-1:0] credit_signal_i,
    output logic [FLIT_WIDTH-1:0]  out_link_o,
    output logic [N_TOT_OF_VC-1:0] out_vc_o,
    output logic                   is_valid_o,
    output logic [N_TOT_OF_VC-1:0] free_signal_o,
    output logic [N_TOT_OF_VC-1:0] fifo_empty_o
`ifdef NIC_OUT_STATS_EN
    ,
    output logic [31:0]            flits_sent_o
`endif
);
    localparam int CW = clog2(MAX_CREDIT + 1);
    localparam logic [N_BITS_POINTER:0] DEPTH = FIFO_DEPTH[N_BITS_POINTER:0];
    localparam logic [CW-1:0] CMAX = MAX_CREDIT[CW-1:0];
    logic in_ok, tail;
    logic [N_TOT_OF_VC-1:0] wr, req, grant;
    logic [N_TOT_OF_VC-1:0][FLIT_WIDTH-1:0] head;
    logic [FLIT_WIDTH-1:0] sel;
    assign in_ok = is_valid_i && in_vc_i != '0 && (in_vc_i & (in_vc_i - 1'b1)) == '0;
    for (genvar v = 0; v < N_TOT_OF_VC; v++) begin : g_vc
        logic [N_BITS_POINTER-1:0] wp, rp;
        logic [N_BITS_POINTER:0] cnt;
        logic [CW-1:0] cr;
        logic [FLIT_WIDTH-1:0] mem [FIFO_DEPTH];
        assign fifo_full_o[v] = cnt == DEPTH;
        assign fifo_empty_o[v] = cnt == '0;
        assign wr[v] = in_ok && in_vc_i[v] && !fifo_full_o[v];
        assign req[v] = !fifo_empty_o[v] && cr != '0;
        assign head[v] = mem[rp];
        always_ff @(posedge clk)
            if (wr[v]) mem[wp] <= in_link_i;
        // A send and a returned credit in the same cycle cancel; returns at MAX_CREDIT are ignored.
        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                wp <= '0;
                rp <= '0;
                cnt <= '0;
                cr <= CMAX;
            end else begin
                if (wr[v]) wp <= wp + 1'b1;
                if (grant[v]) rp <= rp + 1'b1;
                cnt <= cnt + {{N_BITS_POINTER{1'b0}}, wr[v]} - {{N_BITS_POINTER{1'b0}}, grant[v]};
                cr <= (grant[v] && !credit_signal_i[v]) ? cr - 1'b1 :
                      (credit_signal_i[v] && !grant[v] && cr != CMAX) ? cr + 1'b1 : cr;
            end
    end
    nic_rr_arbiter #(.N(N_TOT_OF_VC)) u_arb (
        .clk(clk),
        .rst(rst),
        .request(req),
        .advance(1'b1),
        .grant(grant)
    );
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_TOT_OF_VC; i++) if (grant[i]) sel = head[i];
    end
    assign tail = sel[FLIT_WIDTH-1 -: FLIT_TYPE_W] == TAIL || sel[FLIT_WIDTH-1 -: FLIT_TYPE_W] == HEAD_TAIL;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            out_link_o <= '0;
            out_vc_o <= '0;
            is_valid_o <= 1'b0;
            free_signal_o <= '0;
        end else begin
            out_link_o <= sel;
            out_vc_o <= grant;
            is_valid_o <= |grant;
            free_signal_o <= tail ? grant : '0;
        end
`ifdef NIC_OUT_STATS_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) flits_sent_o <= '0;
        else if (is_valid_o) flits_sent_o <= flits_sent_o + 32'd1;
`endif
endmodule

// File: tb/tb_nic2noc_vc_queue.sv
// tb_nic2noc_vc_queue: directed self-checking bench (6 VCs, depth 4, 2 credits, 16-bit flits).
module tb_nic2noc_vc_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_link_i;
    logic [5:0]  in_vc_i;
    logic        is_valid_i;
    logic [5:0]  fifo_full_o;
    logic [5:0]  credit_signal_i;
    logic [15:0] out_link_o;
    logic [5:0]  out_vc_o;
    logic        is_valid_o;
    logic [5:0]  free_signal_o;
    logic [5:0]  fifo_empty_o;
`ifdef NIC_OUT_STATS_EN
    logic [31:0] flits_sent_o;
`endif
    int checks = 0;
    int errors = 0;

    nic2noc_vc_queue #(
        .N_TOT_OF_VC(6),
        .FIFO_DEPTH(4),
        .FLIT_WIDTH(16),
        .MAX_CREDIT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_link_i(in_link_i),
        .in_vc_i(in_vc_i),
        .is_valid_i(is_valid_i),
        .fifo_full_o(fifo_full_o),
        .credit_signal_i(credit_signal_i),
        .out_link_o(out_link_o),
        .out_vc_o(out_vc_o),
        .is_valid_o(is_valid_o),
        .free_signal_o(free_signal_o),
        .fifo_empty_o(fifo_empty_o)
`ifdef NIC_OUT_STATS_EN
        ,
        .flits_sent_o(flits_sent_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int vc, input logic [15:0] f);
        is_valid_i = 1'b1;
        in_vc_i = 6'(1 << vc);
        in_link_i = f;
    endtask

    task automatic idle;
        is_valid_i = 1'b0;
        in_vc_i = '0;
        in_link_i = '0;
    endtask

    task automatic do_reset;
        idle();
        credit_signal_i = '0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        idle();
        credit_signal_i = '0;
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (is_valid_o !== 1'b0 || out_vc_o !== 6'b0 || out_link_o !== 16'h0 || free_signal_o !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b vc=%b link=%h free=%b want all 0", is_valid_o, out_vc_o, out_link_o, free_signal_o);
        end
        checks++;
        if (fifo_empty_o !== 6'b111111 || fifo_full_o !== 6'b0) begin
            errors++;
            $display("FAIL reset_fifo_flags: got empty=%b full=%b want 111111/000000", fifo_empty_o, fifo_full_o);
        end
        rst = 1'b1;
    endtask

    task automatic test_single;
        put(2, 16'h4015);
        tick();
        idle();
        checks++;
        if (is_valid_o !== 1'b0 || fifo_empty_o !== 6'b111011) begin
            errors++;
            $display("FAIL single_n1: got valid=%b empty=%b want 0/111011", is_valid_o, fifo_empty_o);
        end
        tick();
        checks++;
        if (is_valid_o !== 1'b1 || out_vc_o !== 6'b000100 || out_link_o !== 16'h4015 || free_signal_o !== 6'b0) begin
            errors++;
            $display("FAIL single_out: got valid=%b vc=%b link=%h free=%b want 1/000100/4015/000000", is_valid_o, out_vc_o, out_link_o, free_signal_o);
        end
        tick();
        checks++;
        if (is_valid_o !== 1'b0 || out_link_o !== 16'h0 || out_vc_o !== 6'b0) begin
            errors++;
            $display("FAIL single_idle: got valid=%b vc=%b link=%h want 0/0/0", is_valid_o, out_vc_o, out_link_o);
        end
`ifdef NIC_OUT_STATS_EN
        checks++;
        if (flits_sent_o !== 32'd1) begin
            errors++;
            $display("FAIL stats_count: got %0d want 1", flits_sent_o);
        end
`endif
    endtask

    task automatic test_bad_vc;
        is_valid_i = 1'b1;
        in_vc_i = 6'b000011;
        in_link_i = 16'h8001;
        tick();
        idle();
        checks++;
        if (fifo_empty_o !== 6'b111111) begin
            errors++;
            $display("FAIL bad_vc_write: got empty=%b want 111111", fifo_empty_o);
        end
        tick();
        checks++;
        if (is_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bad_vc_out: got valid=%b want 0", is_valid_o);
        end
    endtask

    task automatic test_full_credit;
        int sent;
        int k;
        logic [15:0] want;
        do_reset();
        sent = 0;
        for (int i = 0; i < 2; i++) begin
            put(0, 16'(16'h4000 + i));
            tick();
            if (is_valid_o) sent++;
        end
        idle();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (is_valid_o) sent++;
        end
        checks++;
        if (sent != 2) begin
            errors++;
            $display("FAIL credit_exhaust: got %0d flits want 2", sent);
        end
        for (int i = 0; i < 5; i++) begin
            put(0, 16'(16'h4010 + i));
            tick();
            if (is_valid_o) sent++;
            if (i == 2) begin
                checks++;
                if (fifo_full_o[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL full_after_3: got %b want 0", fifo_full_o[0]);
                end
            end
            if (i == 3) begin
                checks++;
                if (fifo_full_o !== 6'b000001) begin
                    errors++;
                    $display("FAIL full_after_4: got %b want 000001", fifo_full_o);
                end
            end
        end
        idle();
        tick();
        if (is_valid_o) sent++;
        checks++;
        if (sent != 2) begin
            errors++;
            $display("FAIL no_credit_stall: got %0d flits want 2", sent);
        end
        credit_signal_i = 6'b000001;
        tick();
        credit_signal_i = '0;
        checks++;
        if (is_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL credit_no_bypass: got valid=%b want 0", is_valid_o);
        end
        tick();
        checks++;
        if (is_valid_o !== 1'b1 || out_link_o !== 16'h4010 || out_vc_o !== 6'b000001 || fifo_full_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL one_credit_send: got valid=%b link=%h vc=%b full=%b want 1/4010/000001/0", is_valid_o, out_link_o, out_vc_o, fifo_full_o[0]);
        end
        sent = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (is_valid_o) sent++;
        end
        checks++;
        if (sent != 0) begin
            errors++;
            $display("FAIL one_credit_only: got %0d extra flits want 0", sent);
        end
        credit_signal_i = 6'b000001;
        k = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (is_valid_o) begin
                want = 16'(16'h4010 + k);
                checks++;
                if (out_link_o !== want) begin
                    errors++;
                    $display("FAIL drain_order: got %h want %h", out_link_o, want);
                end
                k++;
            end
        end
        credit_signal_i = '0;
        checks++;
        if (k - 1 != 3 || fifo_empty_o !== 6'b111111) begin
            errors++;
            $display("FAIL fifth_dropped: got %0d drained empty=%b want 3/111111", k - 1, fifo_empty_o);
        end
    endtask

    task automatic test_rr;
        int vcs[6] = '{1, 3, 5, 1, 3, 5};
        logic [15:0] want;
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            if (c <= 6) put(vcs[c-1], 16'(16'h4020 + c - 1));
            else idle();
            tick();
            if (c >= 2 && c <= 7) begin
                want = 16'(16'h4020 + c - 2);
                checks++;
                if (is_valid_o !== 1'b1 || out_vc_o !== 6'(1 << vcs[c-2]) || out_link_o !== want) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got valid=%b vc=%b link=%h want 1/%b/%h", c - 2, is_valid_o, out_vc_o, out_link_o, 6'(1 << vcs[c-2]), want);
                end
            end
        end
        checks++;
        if (is_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rr_end_idle: got valid=%b want 0", is_valid_o);
        end
    endtask

    task automatic test_credit;
        int sent;
        do_reset();
        credit_signal_i = 6'b010000;
        tick();
        credit_signal_i = '0;
        sent = 0;
        for (int i = 0; i < 3; i++) begin
            put(4, 16'(16'h4040 + i));
            tick();
            if (is_valid_o) sent++;
        end
        idle();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (is_valid_o) sent++;
        end
        checks++;
        if (sent != 2) begin
            errors++;
            $display("FAIL credit_saturate: got %0d flits want 2", sent);
        end
        sent = 0;
        credit_signal_i = 6'b010000;
        tick();
        if (is_valid_o) sent++;
        tick();
        if (is_valid_o) sent++;
        credit_signal_i = '0;
        checks++;
        if (sent != 1 || out_link_o !== 16'h4042) begin
            errors++;
            $display("FAIL credit_release: got %0d flits link=%h want 1/4042", sent, out_link_o);
        end
        for (int i = 0; i < 2; i++) begin
            put(4, 16'(16'h4050 + i));
            tick();
            if (is_valid_o) sent++;
        end
        idle();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (is_valid_o) sent++;
        end
        checks++;
        if (sent != 2) begin
            errors++;
            $display("FAIL credit_same_cycle: got %0d flits want 2", sent);
        end
    endtask

    task automatic test_tail;
        logic [15:0] flits[4] = '{16'h0001, 16'h4002, 16'h8003, 16'hC004};
        logic [5:0] want_free;
        do_reset();
        credit_signal_i = 6'b000001;
        for (int c = 1; c <= 6; c++) begin
            if (c <= 4) put(0, flits[c-1]);
            else idle();
            tick();
            if (c >= 2 && c <= 5) begin
                want_free = c >= 4 ? 6'b000001 : 6'b000000;
                checks++;
                if (is_valid_o !== 1'b1 || out_link_o !== flits[c-2] || free_signal_o !== want_free) begin
                    errors++;
                    $display("FAIL tail_free[%0d]: got valid=%b link=%h free=%b want 1/%h/%b", c - 2, is_valid_o, out_link_o, free_signal_o, flits[c-2], want_free);
                end
            end
        end
        credit_signal_i = '0;
        checks++;
        if (is_valid_o !== 1'b0 || free_signal_o !== 6'b0) begin
            errors++;
            $display("FAIL tail_idle: got valid=%b free=%b want 0/000000", is_valid_o, free_signal_o);
        end
    endtask

    task automatic test_reset_mid;
        int sent;
        do_reset();
        for (int v = 0; v < 6; v += 2)
            for (int i = 0; i < 4; i++) begin
                put(v, 16'(16'h8060 + v * 4 + i));
                tick();
            end
        idle();
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (fifo_empty_o !== 6'b101010) begin
            errors++;
            $display("FAIL mid_preload: got empty=%b want 101010", fifo_empty_o);
        end
        credit_signal_i = 6'b000001;
        tick();
        credit_signal_i = '0;
        tick();
        checks++;
        if (is_valid_o !== 1'b1 || free_signal_o !== 6'b000001) begin
            errors++;
            $display("FAIL mid_inflight: got valid=%b free=%b want 1/000001", is_valid_o, free_signal_o);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (is_valid_o !== 1'b0 || out_vc_o !== 6'b0 || out_link_o !== 16'h0 || free_signal_o !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got valid=%b vc=%b link=%h free=%b want all 0", is_valid_o, out_vc_o, out_link_o, free_signal_o);
        end
        checks++;
        if (fifo_empty_o !== 6'b111111 || fifo_full_o !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset_fifos: got empty=%b full=%b want 111111/000000", fifo_empty_o, fifo_full_o);
        end
        tick();
        rst = 1'b1;
        sent = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (is_valid_o) sent++;
        end
        checks++;
        if (sent != 0) begin
            errors++;
            $display("FAIL mid_no_ghost: got %0d flits want 0", sent);
        end
        put(0, 16'h4077);
        tick();
        idle();
        tick();
        checks++;
        if (is_valid_o !== 1'b1 || out_link_o !== 16'h4077 || out_vc_o !== 6'b000001) begin
            errors++;
            $display("FAIL mid_new_write: got valid=%b link=%h vc=%b want 1/4077/000001", is_valid_o, out_link_o, out_vc_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bad_vc();
        test_full_credit();
        test_rr();
        test_credit();
        test_tail();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
